// File: rtl/pc_seq_unit.sv
// pc_seq_unit -- program counter for the MIPS_CPU fetch stage.
//
// Holds the word address of the instruction being fetched and chooses the
// next one: sequential increment, stall, absolute jump or PC-relative branch.
//
// Optional feature, macro PC_CALL_STACK_EN:
//   Adds call/return with a RAS_DEPTH-entry return-address stack.
//   When the stack is full, a call overwrites the oldest entry.
//
// Parameters:
//   ADDR_W     PC width in bits; program memory is 2^ADDR_W words.
//   OFF_W      branch offset width, signed, <= ADDR_W.
//   RESET_ADDR PC value after reset; truncated to ADDR_W.
//   STEP       sequential increment in words.
//   RAS_DEPTH  return-stack entries; power of two, >= 2.
//
// Ports:
//   clk         rising-edge clock.
//   rst         synchronous, active-low reset.
//   en          advance enable; 0 holds the PC.
//   jump_en     load jump_addr.
//   jump_addr   absolute jump target.
//   branch_en   add sign-extended branch_off to pc_out.
//   branch_off  signed branch offset.
//   call_en     (stack only) push pc_seq, then jump to jump_addr.
//   ret_en      (stack only) pop the top entry into the PC.
//   ras_empty   (stack only) stack holds no entries.
//   ras_full    (stack only) stack holds RAS_DEPTH entries.
//   pc_out      registered current PC.
//   pc_seq      pc_out + STEP, combinational, wrapping.
//   redirect    1 for the cycle after a jump/branch/call/ret is taken.
//
// Next-PC priority, highest first: ret, call, jump, branch, stall, increment.
// Redirects are taken even while en is low.
module pc_seq_unit #(
  parameter int ADDR_W     = 10,
  parameter int OFF_W      = 8,
  parameter int RESET_ADDR = 0,
  parameter int STEP       = 1,
  parameter int RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_en,
  input  logic [OFF_W-1:0]  branch_off,
`ifdef PC_CALL_STACK_EN
  input  logic              call_en,
  input  logic              ret_en,
  output logic              ras_empty,
  output logic              ras_full,
`endif
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              redirect
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);
  localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_nxt;
  logic              redirect_nxt;
  logic [ADDR_W-1:0] branch_tgt;

  assign pc_seq = pc_out + STEP_W;

  // Signed cast then resize sign-extends the offset; the add wraps mod 2^ADDR_W.
  assign branch_tgt = pc_out + ADDR_W'($signed(branch_off));

`ifdef PC_CALL_STACK_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  // wr_ptr points at the next free slot; with a power-of-two depth the
  // pointer wraps naturally, so a push when full overwrites the oldest entry.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    ras_count;
  logic [PTR_W-1:0]  top_ptr;
  logic              push;
  logic              pop;

  assign top_ptr   = wr_ptr - PTR_W'(1);
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == DEPTH_C);
`endif

  always_comb begin
    pc_nxt       = pc_out;
    redirect_nxt = 1'b0;
`ifdef PC_CALL_STACK_EN
    push = 1'b0;
    pop  = 1'b0;
    if (ret_en) begin
      // A ret with nothing to pop falls through sequentially, no redirect.
      // A simultaneous call is dropped entirely.
      if (!ras_empty) begin
        pc_nxt       = ras_mem[top_ptr];
        redirect_nxt = 1'b1;
        pop          = 1'b1;
      end else begin
        pc_nxt = pc_seq;
      end
    end else if (call_en) begin
      pc_nxt       = jump_addr;
      redirect_nxt = 1'b1;
      push         = 1'b1;
    end else
`endif
    if (jump_en) begin
      pc_nxt       = jump_addr;
      redirect_nxt = 1'b1;
    end else if (branch_en) begin
      pc_nxt       = branch_tgt;
      redirect_nxt = 1'b1;
    end else if (en) begin
      pc_nxt = pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_out   <= RESET_PC;
      redirect <= 1'b0;
    end else begin
      pc_out   <= pc_nxt;
      redirect <= redirect_nxt;
    end
  end

`ifdef PC_CALL_STACK_EN
  // Entries need no reset: ras_count gates every read.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      ras_mem[wr_ptr] <= pc_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      ras_count <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!ras_full) begin
        ras_count <= ras_count + (PTR_W + 1)'(1);
      end
    end else if (pop) begin
      wr_ptr    <= top_ptr;
      ras_count <= ras_count - (PTR_W + 1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit -- directed bench for pc_seq_unit with default parameters
// (ADDR_W = 10, OFF_W = 8, RESET_ADDR = 0, STEP = 1, RAS_DEPTH = 4).
// The call/return section is compiled only when PC_CALL_STACK_EN is defined.
module tb_pc_seq_unit;

  localparam int ADDR_W = 10;
  localparam int OFF_W  = 8;

  // Clock / reset block.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              en;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              branch_en;
  logic [OFF_W-1:0]  branch_off;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_seq;
  logic              redirect;
`ifdef PC_CALL_STACK_EN
  logic              call_en;
  logic              ret_en;
  logic              ras_empty;
  logic              ras_full;
`endif

  int checks   = 0;
  int failures = 0;

  pc_seq_unit dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .branch_en  (branch_en),
    .branch_off (branch_off),
`ifdef PC_CALL_STACK_EN
    .call_en    (call_en),
    .ret_en     (ret_en),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
`endif
    .pc_out     (pc_out),
    .pc_seq     (pc_seq),
    .redirect   (redirect)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b0;
    en         = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = '0;
    branch_en  = 1'b0;
    branch_off = '0;
`ifdef PC_CALL_STACK_EN
    call_en    = 1'b0;
    ret_en     = 1'b0;
`endif

    // Reset state.
    tick();
    tick();
    chk("reset_pc", 32'(pc_out), 32'h000);
    chk("reset_redirect", 32'(redirect), 32'h0);
    chk("reset_pc_seq", 32'(pc_seq), 32'h001);

    // Sequential increment 1..5.
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("inc_pc", 32'(pc_out), 32'(i));
      chk("inc_redirect", 32'(redirect), 32'h0);
      chk("inc_pc_seq", 32'(pc_seq), 32'(i + 1));
    end

    // Count up to 0x3FF, then wrap.
    repeat (32'h3FA) tick();
    chk("top_pc", 32'(pc_out), 32'h3FF);
    chk("top_pc_seq_wrap", 32'(pc_seq), 32'h000);
    tick();
    chk("wrap_pc", 32'(pc_out), 32'h000);

    // Stall holds.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(pc_out), 32'h000);
      chk("stall_redirect", 32'(redirect), 32'h0);
    end

    // Branch backwards with underflow: 0x005 + (-8) = 0x3FD.
    en = 1'b1;
    repeat (5) tick();
    chk("pre_branch_pc", 32'(pc_out), 32'h005);
    branch_en  = 1'b1;
    branch_off = 8'hF8;
    tick();
    chk("branch_neg_pc", 32'(pc_out), 32'h3FD);
    chk("branch_neg_redirect", 32'(redirect), 32'h1);

    // Jump beats branch and overrides a stall; redirect stays high back-to-back.
    jump_en   = 1'b1;
    jump_addr = 10'h120;
    en        = 1'b0;
    tick();
    chk("jump_pc", 32'(pc_out), 32'h120);
    chk("jump_redirect", 32'(redirect), 32'h1);
    jump_en   = 1'b0;
    branch_en = 1'b0;
    tick();
    chk("post_jump_pc", 32'(pc_out), 32'h120);
    chk("post_jump_redirect", 32'(redirect), 32'h0);

    // Forward branch with overflow: 0x3F0 + 0x20 = 0x010.
    jump_en   = 1'b1;
    jump_addr = 10'h3F0;
    tick();
    jump_en    = 1'b0;
    branch_en  = 1'b1;
    branch_off = 8'h20;
    tick();
    chk("branch_pos_pc", 32'(pc_out), 32'h010);
    branch_en = 1'b0;

    // Reset beats a jump on the same edge.
    en        = 1'b1;
    rst       = 1'b0;
    jump_en   = 1'b1;
    jump_addr = 10'h200;
    tick();
    chk("rst_jump_pc", 32'(pc_out), 32'h000);
    chk("rst_jump_redirect", 32'(redirect), 32'h0);
    // Releasing reset between edges changes nothing until the next edge.
    jump_en = 1'b0;
    rst     = 1'b1;
    #2;
    chk("rst_release_hold", 32'(pc_out), 32'h000);
    tick();
    chk("rst_release_inc", 32'(pc_out), 32'h001);

`ifdef PC_CALL_STACK_EN
    rst = 1'b0;
    en  = 1'b0;
    tick();
    rst = 1'b1;
    chk("ras_reset_empty", 32'(ras_empty), 32'h1);
    chk("ras_reset_full", 32'(ras_full), 32'h0);

    // Five calls from 0x010..0x014; the fifth overwrites the return to 0x011.
    for (int k = 0; k < 5; k++) begin
      jump_en   = 1'b1;
      jump_addr = 10'(32'h010 + k);
      tick();
      jump_en   = 1'b0;
      call_en   = 1'b1;
      jump_addr = 10'h100;
      tick();
      call_en = 1'b0;
      chk("call_pc", 32'(pc_out), 32'h100);
      chk("call_redirect", 32'(redirect), 32'h1);
      chk("call_full", 32'(ras_full), (k >= 3) ? 32'h1 : 32'h0);
    end

    for (int k = 0; k < 4; k++) begin
      ret_en = 1'b1;
      tick();
      chk("ret_pc", 32'(pc_out), 32'(32'h015 - k));
      chk("ret_redirect", 32'(redirect), 32'h1);
      chk("ret_full", 32'(ras_full), 32'h0);
      chk("ret_empty", 32'(ras_empty), (k == 3) ? 32'h1 : 32'h0);
    end

    // Ret on an empty stack falls through sequentially: 0x012 -> 0x013.
    tick();
    ret_en = 1'b0;
    chk("ret_empty_pc", 32'(pc_out), 32'h013);
    chk("ret_empty_redirect", 32'(redirect), 32'h0);
    chk("ret_empty_still", 32'(ras_empty), 32'h1);

    // Simultaneous call and ret with one entry 0x040: ret wins, call dropped.
    jump_en   = 1'b1;
    jump_addr = 10'h03F;
    tick();
    jump_en   = 1'b0;
    call_en   = 1'b1;
    jump_addr = 10'h100;
    tick();
    chk("one_entry_pc", 32'(pc_out), 32'h100);
    ret_en    = 1'b1;
    jump_addr = 10'h200;
    tick();
    call_en = 1'b0;
    ret_en  = 1'b0;
    chk("call_ret_pc", 32'(pc_out), 32'h040);
    chk("call_ret_empty", 32'(ras_empty), 32'h1);
    chk("call_ret_redirect", 32'(redirect), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised program counter for the MIPS_CPU fetch stage; generation after the plain increment-only counter.
- Addresses program memory with a configurable word-address width.
- Adds stall, absolute jump, PC-relative branch, a redirect flag, and an optional call/return stack.

Parameters:
- ADDR_W, 10, PC width in bits; program memory depth is 2^ADDR_W words.
- OFF_W, 8, width of signed two's-complement branch offset; must be <= ADDR_W.
- RESET_ADDR, 0, value loaded into the PC on reset; truncated to ADDR_W.
- STEP, 1, sequential increment in words.
- RAS_DEPTH, 4, return-stack entries; used only with PC_CALL_STACK_EN; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  advance enable; 0 = stall, PC holds.
- jump_en  in  1  load the absolute target.
- jump_addr  in  ADDR_W  absolute jump target.
- branch_en  in  1  take a relative branch.
- branch_off  in  OFF_W  signed offset, relative to the current pc_out.
- pc_out  out  ADDR_W  registered current PC.
- pc_seq  out  ADDR_W  combinational: pc_out + STEP, modulo 2^ADDR_W.
- redirect  out  1  registered; 1 for the single cycle after a jump/branch/ret is taken.
- call_en  in  1  (PC_CALL_STACK_EN only) push pc_seq, then jump to jump_addr.
- ret_en  in  1  (PC_CALL_STACK_EN only) pop the top entry into the PC.
- ras_empty  out  1  (PC_CALL_STACK_EN only) stack holds no entries.
- ras_full  out  1  (PC_CALL_STACK_EN only) stack holds RAS_DEPTH entries.

Behaviour:
- rst is sampled only at the rising edge of clk. While rst == 0:
  - pc_out <= RESET_ADDR, redirect <= 0.
  - Stack count <= 0, so ras_empty = 1 and ras_full = 0.
  - All other inputs are ignored.
- Priority at each edge with rst == 1 (highest first):
  - ret_en
  - call_en
  - jump_en
  - branch_en
  - en == 0, stall
  - increment
- Redirects (jump, branch, call, ret) are taken even when en == 0; a redirect overrides a stall.
- jump: pc_out <= jump_addr.
- branch: pc_out <= pc_out + sign_extend(branch_off).
  - Computed modulo 2^ADDR_W; overflow and underflow wrap silently.
  - Example, ADDR_W = 10: 0x005 + (-8) = 0x3FD.
- increment: pc_out <= pc_out + STEP, wrapping. Example: 0x3FF to 0x000 with STEP = 1.
- stall: pc_out and the stack hold; redirect <= 0.
- redirect:
  - redirect <= 1 on the edge where a jump, branch, call or ret is taken; otherwise redirect <= 0.
  - Back-to-back redirects keep redirect high on consecutive cycles.
- Latency: every input is reflected in pc_out one clock after the sampling edge. pc_seq tracks pc_out combinationally.
- Reset mid-operation: reset wins over every other input on the same edge; there is no partial update.

Optional Feature:
- Macro PC_CALL_STACK_EN.
- Defined:
  - Adds call_en, ret_en, ras_empty, ras_full and a RAS_DEPTH x ADDR_W LIFO.
- call:
  - Pushes pc_seq, sets pc_out <= jump_addr, redirect <= 1.
  - When ras_full, the oldest entry is discarded (circular overwrite): the push succeeds, count stays RAS_DEPTH.
- ret:
  - Pops the top entry into pc_out, redirect <= 1.
  - When ras_empty, pc_out <= pc_seq (sequential), redirect <= 0, and the count stays 0 (no underflow).
- call_en and ret_en together:
  - ret is performed.
  - The call is dropped entirely: no push, and jump_addr is not loaded.
- Not defined: those four ports and the stack logic do not exist; behaviour is exactly as specified above without them.

Test Plan:
- Reset, then 5 cycles with en = 1 (ADDR_W = 10, RESET_ADDR = 0) -> pc_out 0,1,2,3,4,5; redirect = 0; pc_seq = pc_out + 1.
- Count with en = 1 until pc_out = 0x3FF, then one more edge -> pc_out = 0x000; with en = 0 for 3 cycles -> pc_out holds.
- At pc_out = 0x005: branch_en = 1, branch_off = -8 -> pc_out = 0x3FD and redirect = 1 for one cycle. Then jump_en = 1 and branch_en = 1, jump_addr = 0x120, en = 0 -> pc_out = 0x120 (jump wins and overrides the stall).
- rst = 0 asserted for one edge while jump_en = 1 -> pc_out = RESET_ADDR, redirect = 0; deasserting rst between edges has no effect until the next edge.
- PC_CALL_STACK_EN, RAS_DEPTH = 4:
  - Stimulus: 5 calls from PCs 0x010..0x014 (jump_addr 0x100), then 5 rets.
  - Required: ret targets 0x015, 0x014, 0x013, 0x012; the fifth ret gives pc_seq with redirect = 0; ras_full = 1 after the 4th call; ras_empty = 1 after the 4th ret.
- PC_CALL_STACK_EN: call_en = 1 and ret_en = 1 with one entry 0x040 on the stack -> pc_out = 0x040, ras_empty = 1.
